// File: rtl/mac_wb_pkg.sv
// Shared types and defaults for the MAC register-bus Wishbone arbiter.
package mac_wb_pkg;

    localparam int MAC_REG_ADDR_W = 8;
    localparam int DEFAULT_ADDR_W = MAC_REG_ADDR_W;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mac_wb_watchdog.sv
// Strobe watchdog: counts unacknowledged strobe cycles and flags err_now for one
// cycle when the count reaches TIMEOUT. TIMEOUT of 0 disables it.
module mac_wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic stb,
    input  logic ack,
    output logic err_now
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt;

    // An ack in the limit cycle wins over the timeout.
    assign err_now = (TIMEOUT != 0) && (cnt == LIMIT) && !ack;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (TIMEOUT == 0 || ack || !stb || err_now) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mac_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the 10G MAC register slave;
// a bus cycle stays with its owner until that owner drops cyc.
module mac_wb_arbiter
    import mac_wb_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_adr_i,
    input  logic [DATA_W-1:0] m0_dat_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic [DATA_W-1:0] m0_dat_o,
    output logic              m0_int_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_adr_i,
    input  logic [DATA_W-1:0] m1_dat_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [DATA_W-1:0] m1_dat_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    input  logic              wb_ack_i,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_int_i
);

    arb_state_e state;
    logic       last_grant;
    logic       err_now;
    logic       wd_stb;

    // The host owns MAC interrupts; pass through even during reset.
    assign m0_int_o = wb_int_i;

    // An abandoned strobe (cyc dropped) must not keep the watchdog running.
    assign wd_stb = wb_cyc_o & wb_stb_o;

    mac_wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .stb     (wd_stb),
        .ack     (wb_ack_i),
        .err_now (err_now)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    // On a tie the master that was not granted last wins.
                    if (m0_cyc_i && (!m1_cyc_i || last_grant)) begin
                        state      <= OWN0;
                        last_grant <= 1'b0;
                    end else if (m1_cyc_i) begin
                        state      <= OWN1;
                        last_grant <= 1'b1;
                    end
                end
                OWN0:    if (!m0_cyc_i) state <= IDLE;
                OWN1:    if (!m1_cyc_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case, so no path through
    // this block can leave a value unassigned and infer a latch.
    always_comb begin
        wb_cyc_o = 1'b0;
        wb_stb_o = 1'b0;
        wb_we_o  = 1'b0;
        wb_adr_o = '0;
        wb_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_dat_o = '0;
        unique case (state)
            OWN0: begin
                wb_cyc_o = m0_cyc_i;
                wb_stb_o = m0_stb_i & ~err_now;
                wb_we_o  = m0_we_i;
                wb_adr_o = m0_adr_i;
                wb_dat_o = m0_dat_i;
                m0_ack_o = wb_ack_i & m0_stb_i;
                m0_err_o = err_now;
                m0_dat_o = (wb_ack_i & m0_stb_i) ? wb_dat_i : '0;
            end
            OWN1: begin
                wb_cyc_o = m1_cyc_i;
                wb_stb_o = m1_stb_i & ~err_now;
                wb_we_o  = m1_we_i;
                wb_adr_o = m1_adr_i;
                wb_dat_o = m1_dat_i;
                m1_ack_o = wb_ack_i & m1_stb_i;
                m1_err_o = err_now;
                m1_dat_o = (wb_ack_i & m1_stb_i) ? wb_dat_i : '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mac_wb_arbiter.sv
// Cycle-table bench for mac_wb_arbiter with TIMEOUT=4: each row drives one cycle
// and carries the outputs expected in that cycle.
module tb_mac_wb_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 4;

    localparam logic          M0_WE  = 1'b1;
    localparam logic [AW-1:0] M0_ADR = 8'h00;
    localparam logic [DW-1:0] M0_WD  = 32'h0000_0001;
    localparam logic          M1_WE  = 1'b0;
    localparam logic [AW-1:0] M1_ADR = 8'h10;
    localparam logic [DW-1:0] M1_WD  = 32'hA5A5_0001;

    logic          wb_clk_i, wb_rst_i;
    logic          m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0] m0_adr_i, m1_adr_i, wb_adr_o;
    logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, wb_dat_o, wb_dat_i;
    logic          m0_ack_o, m0_err_o, m0_int_o, m1_ack_o, m1_err_o;
    logic          wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, wb_int_i;

    mac_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
        .m0_cyc_i (m0_cyc_i), .m0_stb_i (m0_stb_i), .m0_we_i (m0_we_i),
        .m0_adr_i (m0_adr_i), .m0_dat_i (m0_dat_i),
        .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o), .m0_dat_o (m0_dat_o),
        .m0_int_o (m0_int_o),
        .m1_cyc_i (m1_cyc_i), .m1_stb_i (m1_stb_i), .m1_we_i (m1_we_i),
        .m1_adr_i (m1_adr_i), .m1_dat_i (m1_dat_i),
        .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o), .m1_dat_o (m1_dat_o),
        .wb_cyc_o (wb_cyc_o), .wb_stb_o (wb_stb_o), .wb_we_o (wb_we_o),
        .wb_adr_o (wb_adr_o), .wb_dat_o (wb_dat_o),
        .wb_ack_i (wb_ack_i), .wb_dat_i (wb_dat_i), .wb_int_i (wb_int_i)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    // One cycle of stimulus plus expectations; own: 0 none, 1 master 0, 2 master 1.
    typedef struct {
        logic          rst;
        logic [1:0]    cyc, stb;  // bit 0 master 0, bit 1 master 1
        logic          ack;
        logic [DW-1:0] sdat;
        logic          intr;
        logic [1:0]    own;
        logic          ecyc, estb;
        logic [1:0]    eack, eerr;
    } vec_t;

    typedef struct packed {
        logic          cyc, stb, we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic          ack0, err0;
        logic [DW-1:0] dat0;
        logic          ack1, err1;
        logic [DW-1:0] dat1;
        logic          intr;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic rst, input logic [1:0] cyc, input logic [1:0] stb,
                                input logic ack, input logic [DW-1:0] sdat, input logic intr,
                                input logic [1:0] own, input logic ecyc, input logic estb,
                                input logic [1:0] eack, input logic [1:0] eerr);
        vec_t v;
        v.rst = rst; v.cyc = cyc; v.stb = stb; v.ack = ack; v.sdat = sdat; v.intr = intr;
        v.own = own; v.ecyc = ecyc; v.estb = estb; v.eack = eack; v.eerr = eerr;
        vecs.push_back(v);
    endfunction

    function automatic exp_t expect_of(input vec_t v);
        exp_t e = '0;
        e.cyc = v.ecyc;
        e.stb = v.estb;
        if (v.own == 2'd1) begin
            e.we = M0_WE; e.adr = M0_ADR; e.dat = M0_WD;
        end else if (v.own == 2'd2) begin
            e.we = M1_WE; e.adr = M1_ADR; e.dat = M1_WD;
        end
        e.ack0 = v.eack[0];
        e.err0 = v.eerr[0];
        e.dat0 = v.eack[0] ? v.sdat : '0;
        e.ack1 = v.eack[1];
        e.err1 = v.eerr[1];
        e.dat1 = v.eack[1] ? v.sdat : '0;
        e.intr = v.intr;
        return e;
    endfunction

    task automatic apply(input vec_t v);
        wb_rst_i = v.rst;
        m0_cyc_i = v.cyc[0]; m0_stb_i = v.stb[0];
        m1_cyc_i = v.cyc[1]; m1_stb_i = v.stb[1];
        wb_ack_i = v.ack;
        wb_dat_i = v.sdat;
        wb_int_i = v.intr;
        sb.push_back(expect_of(v));
    endtask

    task automatic compare(input int i);
        exp_t e;
        string p;
        e = sb.pop_front();
        p = $sformatf("v%0d", i);
        check({p, " wb_cyc"}, DW'(wb_cyc_o), DW'(e.cyc));
        check({p, " wb_stb"}, DW'(wb_stb_o), DW'(e.stb));
        check({p, " wb_we"},  DW'(wb_we_o),  DW'(e.we));
        check({p, " wb_adr"}, DW'(wb_adr_o), DW'(e.adr));
        check({p, " wb_dat"}, wb_dat_o,      e.dat);
        check({p, " m0_ack"}, DW'(m0_ack_o), DW'(e.ack0));
        check({p, " m0_err"}, DW'(m0_err_o), DW'(e.err0));
        check({p, " m0_dat"}, m0_dat_o,      e.dat0);
        check({p, " m1_ack"}, DW'(m1_ack_o), DW'(e.ack1));
        check({p, " m1_err"}, DW'(m1_err_o), DW'(e.err1));
        check({p, " m1_dat"}, m1_dat_o,      e.dat1);
        check({p, " m0_int"}, DW'(m0_int_o), DW'(e.intr));
    endtask

    initial begin
        wb_rst_i = 1'b1;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = M0_WE; m0_adr_i = M0_ADR; m0_dat_i = M0_WD;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = M1_WE; m1_adr_i = M1_ADR; m1_dat_i = M1_WD;
        wb_ack_i = 1'b0; wb_dat_i = '0; wb_int_i = 1'b0;

        // Reset state; interrupt still passes through.
        add(1, 2'b00, 2'b00, 0, 32'h0, 1, 0, 0, 0, 2'b00, 2'b00);
        add(1, 2'b00, 2'b00, 0, 32'h0, 0, 0, 0, 0, 2'b00, 2'b00);

        // Master 0 alone writes 1 to 0x00, slave acks on the second strobe cycle.
        add(0, 2'b01, 2'b01, 0, 32'h0,         0, 0, 0, 0, 2'b00, 2'b00);
        add(0, 2'b01, 2'b01, 0, 32'h0BAD_F00D, 0, 1, 1, 1, 2'b00, 2'b00);
        add(0, 2'b01, 2'b01, 1, 32'h0BAD_F00D, 0, 1, 1, 1, 2'b01, 2'b00);
        add(0, 2'b00, 2'b00, 0, 32'h0,         1, 1, 0, 0, 2'b00, 2'b00);
        add(0, 2'b00, 2'b00, 0, 32'h0,         0, 0, 0, 0, 2'b00, 2'b00);

        // Ties under continuous contention after reset: m0, m1, m0.
        add(1, 2'b00, 2'b00, 0, 32'h0,         0, 0, 0, 0, 2'b00, 2'b00);
        add(0, 2'b11, 2'b11, 0, 32'h0,         0, 0, 0, 0, 2'b00, 2'b00);
        add(0, 2'b11, 2'b11, 1, 32'h1111_2222, 0, 1, 1, 1, 2'b01, 2'b00);
        add(0, 2'b10, 2'b10, 0, 32'h0,         0, 1, 0, 0, 2'b00, 2'b00);
        add(0, 2'b11, 2'b11, 0, 32'h0,         0, 0, 0, 0, 2'b00, 2'b00);
        add(0, 2'b11, 2'b11, 1, 32'hDEAD_BEEF, 0, 2, 1, 1, 2'b10, 2'b00);
        add(0, 2'b11, 2'b11, 0, 32'hDEAD_BEEF, 0, 2, 1, 1, 2'b00, 2'b00);
        add(0, 2'b01, 2'b01, 0, 32'h0,         0, 2, 0, 0, 2'b00, 2'b00);
        add(0, 2'b11, 2'b11, 0, 32'h0,         0, 0, 0, 0, 2'b00, 2'b00);
        add(0, 2'b11, 2'b11, 0, 32'h0,         0, 1, 1, 1, 2'b00, 2'b00);
        add(0, 2'b10, 2'b10, 0, 32'h0,         0, 1, 0, 0, 2'b00, 2'b00);
        add(0, 2'b00, 2'b00, 0, 32'h0,         0, 0, 0, 0, 2'b00, 2'b00);

        // Watchdog: no ack, error 5 cycles after the first request, then a retry.
        add(1, 2'b00, 2'b00, 0, 32'h0, 0, 0, 0, 0, 2'b00, 2'b00);
        add(0, 2'b01, 2'b01, 0, 32'h0, 0, 0, 0, 0, 2'b00, 2'b00);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < TO; k++) add(0, 2'b01, 2'b01, 0, 32'h0, 0, 1, 1, 1, 2'b00, 2'b00);
            add(0, 2'b01, 2'b01, 0, 32'h0, 0, 1, 1, 0, 2'b00, 2'b01);
        end
        add(0, 2'b00, 2'b00, 0, 32'h0, 0, 1, 0, 0, 2'b00, 2'b00);
        add(0, 2'b00, 2'b00, 0, 32'h0, 0, 0, 0, 0, 2'b00, 2'b00);

        // Ack arriving exactly when the counter reaches TIMEOUT wins.
        add(0, 2'b01, 2'b01, 0, 32'h0, 0, 0, 0, 0, 2'b00, 2'b00);
        for (int k = 0; k < TO; k++) add(0, 2'b01, 2'b01, 0, 32'h0, 0, 1, 1, 1, 2'b00, 2'b00);
        add(0, 2'b01, 2'b01, 1, 32'h1234_5678, 0, 1, 1, 1, 2'b01, 2'b00);
        add(0, 2'b00, 2'b00, 0, 32'h0,         0, 1, 0, 0, 2'b00, 2'b00);
        add(0, 2'b00, 2'b00, 0, 32'h0,         0, 0, 0, 0, 2'b00, 2'b00);

        // Reset while master 1 owns the bus, then a tie goes to master 0.
        add(0, 2'b10, 2'b10, 0, 32'h0,         0, 0, 0, 0, 2'b00, 2'b00);
        add(0, 2'b10, 2'b10, 0, 32'h0,         0, 2, 1, 1, 2'b00, 2'b00);
        add(0, 2'b10, 2'b10, 0, 32'h0,         0, 2, 1, 1, 2'b00, 2'b00);
        add(1, 2'b10, 2'b10, 1, 32'h5555_AAAA, 1, 0, 0, 0, 2'b00, 2'b00);
        add(0, 2'b11, 2'b11, 0, 32'h0,         0, 0, 0, 0, 2'b00, 2'b00);
        add(0, 2'b11, 2'b11, 0, 32'h0,         0, 1, 1, 1, 2'b00, 2'b00);
        add(0, 2'b10, 2'b10, 0, 32'h0,         0, 1, 0, 0, 2'b00, 2'b00);
        add(0, 2'b10, 2'b10, 0, 32'h0,         0, 0, 0, 0, 2'b00, 2'b00);
        add(0, 2'b10, 2'b10, 1, 32'hCAFE_0010, 0, 2, 1, 1, 2'b10, 2'b00);
        add(0, 2'b00, 2'b00, 0, 32'h0,         0, 2, 0, 0, 2'b00, 2'b00);
        add(0, 2'b00, 2'b00, 0, 32'h0,         0, 0, 0, 0, 2'b00, 2'b00);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge wb_clk_i);
            #1;
            apply(vecs[i]);
            @(negedge wb_clk_i);
            compare(i);
        end

        check("scoreboard_drained", DW'(sb.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
